mdu_iterative: RTL and testbench

- Multi-cycle multiply/divide responder that sits beside the combinational ALU in the execute stage.
- Accepts one operation request (a, b, mdu_control_t) over a valid/ready handshake.
- Computes iteratively, one bit per cycle, then presents result and flags until the requester takes them.
- Operation set and result semantics follow RV32M (funct3 encoding).

---
 rtl/mdu_iterative_pkg.sv | 42 ++++
 rtl/mdu_iterative_step.sv | 34 +++
 rtl/mdu_iterative.sv | 137 +++++++++++++
 tb/tb_mdu_iterative.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iterative_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encoding
// (RV32M funct3), controller states and small operation-class helpers.
package mdu_iterative_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_control_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

    function automatic logic op_is_div(input mdu_control_t c);
        return c[2];
    endfunction

    function automatic logic op_is_rem(input mdu_control_t c);
        return c[2] & c[1];
    endfunction

    function automatic logic op_signed_a(input mdu_control_t c);
        return (c == MDU_MULH) || (c == MDU_MULHSU) || (c == MDU_DIV) || (c == MDU_REM);
    endfunction

    function automatic logic op_signed_b(input mdu_control_t c);
        return (c == MDU_MULH) || (c == MDU_DIV) || (c == MDU_REM);
    endfunction

    function automatic string mdu_control_name(input mdu_control_t c);
        return c.name();
    endfunction

endpackage

// File: rtl/mdu_iterative_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring shift-subtract divide step on the {acc, shreg} register pair.
module mdu_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] acc,
    input  logic [N-1:0] shreg,
    input  logic [N-1:0] operand,
    input  logic         is_div,
    output logic [N-1:0] acc_next,
    output logic [N-1:0] shreg_next
);

    logic [N:0]   sum;
    logic [N:0]   trial;
    logic [N-1:0] diff;
    logic         fits;

    always_comb begin
        sum   = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
        trial = {acc, shreg[N-1]};
        fits  = (trial >= {1'b0, operand});
        // trial < 2*operand holds, so a successful subtraction always fits in N bits
        diff  = trial[N-1:0] - operand;
        if (is_div) begin
            acc_next   = fits ? diff : trial[N-1:0];
            shreg_next = {shreg[N-2:0], fits};
        end else begin
            acc_next   = sum[N:1];
            shreg_next = {sum[0], shreg[N-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M multiply/divide unit: valid/ready request, N single-bit
// iterations on operand magnitudes, sign fix-up and special cases at the end.
module mdu_iterative
    import mdu_iterative_pkg::*;
#(
    parameter int N  = 32,
    parameter int CW = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  mdu_control_t control,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         overflow,
    output logic         div_by_zero
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mdu_state_t   state;
    logic [CW-1:0] count;
    mdu_control_t op;
    logic [N-1:0] acc;
    logic [N-1:0] shreg;
    logic [N-1:0] operand;
    logic [N-1:0] a_keep;
    logic         neg_res;
    logic         dbz;
    logic         ovf;

    logic [N-1:0]   acc_next;
    logic [N-1:0]   shreg_next;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quot;
    logic [N-1:0]   rem;
    logic [N-1:0]   final_res;

    logic         a_neg;
    logic         b_neg;
    logic [N-1:0] mag_a;
    logic [N-1:0] mag_b;

    function automatic logic [N-1:0] cond_negate(input logic [N-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign o_ready = (state == S_IDLE);

    mdu_step #(.N(N)) u_step (
        .acc        (acc),
        .shreg      (shreg),
        .operand    (operand),
        .is_div     (op_is_div(op)),
        .acc_next   (acc_next),
        .shreg_next (shreg_next)
    );

    always_comb begin
        a_neg = op_signed_a(control) & a[N-1];
        b_neg = op_signed_b(control) & b[N-1];
        mag_a = cond_negate(a, a_neg);
        mag_b = cond_negate(b, b_neg);
    end

    // Sign correction and special-case override on the final iteration's output
    always_comb begin
        prod = neg_res ? (~{acc_next, shreg_next} + 1'b1) : {acc_next, shreg_next};
        quot = cond_negate(shreg_next, neg_res);
        rem  = cond_negate(acc_next, neg_res);
        case (op)
            MDU_MUL:                         final_res = prod[N-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = prod[2*N-1:N];
            MDU_DIV, MDU_DIVU:
                final_res = dbz ? '1 : (ovf ? {1'b1, {(N-1){1'b0}}} : quot);
            default:
                final_res = dbz ? a_keep : (ovf ? '0 : rem);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= '0;
            o_valid     <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        op      <= control;
                        a_keep  <= a;
                        acc     <= '0;
                        count   <= '0;
                        // Divide keeps the dividend in shreg; multiply keeps the multiplier there
                        operand <= op_is_div(control) ? mag_b : mag_a;
                        shreg   <= op_is_div(control) ? mag_a : mag_b;
                        neg_res <= op_is_rem(control) ? a_neg : (a_neg ^ b_neg);
                        dbz     <= op_is_div(control) && (b == '0);
                        ovf     <= control[2] && !control[0]
                                   && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc   <= acc_next;
                    shreg <= shreg_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        result      <= final_res;
                        zero        <= (final_res == '0);
                        overflow    <= ovf;
                        div_by_zero <= dbz;
                        o_valid     <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed RV32M cases, backpressure,
// mid-operation reset and randomized requests against a behavioural model.
module tb_mdu_iterative;
    import mdu_iterative_pkg::*;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    mdu_control_t control;
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] result;
    logic         zero;
    logic         overflow;
    logic         div_by_zero;

    typedef struct {
        mdu_control_t op;
        logic [31:0]  res;
        logic         z;
        logic         ov;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mdu_iterative #(.N(N), .CW(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .a           (a),
        .b           (b),
        .control     (control),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no completion, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    endtask

    function automatic void mdu_behavioural(input mdu_control_t op, input logic [31:0] x, input logic [31:0] y,
                                            output logic [31:0] r, output logic ov, output logic dz);
        logic signed [63:0] sx, sy, ux, uy, p;
        logic signed [31:0] qx, qy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        qx = x;
        qy = y;
        ov = 1'b0;
        dz = 1'b0;
        r  = '0;
        case (op)
            MDU_MUL:    begin p = sx * sy; r = p[31:0];  end
            MDU_MULH:   begin p = sx * sy; r = p[63:32]; end
            MDU_MULHSU: begin p = sx * uy; r = p[63:32]; end
            MDU_MULHU:  begin p = ux * uy; r = p[63:32]; end
            MDU_DIV: begin
                if (y == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = 32'h8000_0000; ov = 1'b1; end
                else r = qx / qy;
            end
            MDU_DIVU: begin
                if (y == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
                else r = x / y;
            end
            MDU_REM: begin
                if (y == 0) begin r = x; dz = 1'b1; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = 0; ov = 1'b1; end
                else r = qx % qy;
            end
            default: begin
                if (y == 0) begin r = x; dz = 1'b1; end
                else r = x % y;
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input mdu_control_t op, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   guard = 0;
        while (!o_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", 64'(guard < 200), 64'd1);
        i_valid = 1'b1;
        a       = x;
        b       = y;
        control = op;
        e.op    = op;
        mdu_behavioural(op, x, y, e.res, e.ov, e.dz);
        e.z     = (e.res == 0);
        sb.push_back(e);
        @(negedge clk);
        i_valid = 1'b0;
        a       = $urandom;
        b       = $urandom;
        control = mdu_control_t'(3'($urandom));
    endtask

    task automatic complete(input int hold);
        exp_t        e;
        string       nm;
        logic [31:0] r0;
        int          lat = 0;
        while (!o_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(N));
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'(sb.size()), 64'd1);
        end else begin
            e  = sb.pop_front();
            nm = mdu_control_name(e.op);
            check({nm, "_result"}, 64'(result), 64'(e.res));
            check({nm, "_zero"}, 64'(zero), 64'(e.z));
            check({nm, "_overflow"}, 64'(overflow), 64'(e.ov));
            check({nm, "_div_by_zero"}, 64'(div_by_zero), 64'(e.dz));
        end
        r0 = result;
        for (int i = 0; i < hold; i++) begin
            i_valid = 1'b1;
            a       = $urandom;
            b       = $urandom;
            @(negedge clk);
            check("hold_valid", 64'(o_valid), 64'd1);
            check("hold_result", 64'(result), 64'(r0));
            check("hold_ready", 64'(o_ready), 64'd0);
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("consume_valid", 64'(o_valid), 64'd0);
        check("consume_ready", 64'(o_ready), 64'd1);
        i_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] x, y;
        int          sel;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        a       = '0;
        b       = '0;
        control = MDU_MUL;
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(o_valid), 64'd0);
        check("reset_ready", 64'(o_ready), 64'd1);
        check("reset_result", 64'(result), 64'd0);
        check("reset_flags", 64'({zero, overflow, div_by_zero}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(MDU_MUL,   32'h0000_0007, 32'hFFFF_FFFD); complete(0);
        issue(MDU_MULH,  32'h0000_0007, 32'hFFFF_FFFD); complete(0);
        issue(MDU_MULHU, 32'h0000_0007, 32'hFFFF_FFFD); complete(0);
        issue(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002); complete(0);
        issue(MDU_REM,   32'hFFFF_FFF9, 32'h0000_0002); complete(0);
        issue(MDU_DIVU,  32'h0000_0007, 32'h0000_0002); complete(0);
        issue(MDU_REMU,  32'h0000_0007, 32'h0000_0002); complete(0);
        issue(MDU_DIVU,  32'h0000_1234, 32'h0000_0000); complete(0);
        issue(MDU_REM,   32'h0000_1234, 32'h0000_0000); complete(0);
        issue(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF); complete(0);
        issue(MDU_REM,   32'h8000_0000, 32'hFFFF_FFFF); complete(0);
        issue(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); complete(5);
        issue(MDU_DIVU,  32'h0000_0007, 32'h0000_0002); complete(5);

        // Abort a request partway through the iterations
        issue(MDU_DIVU, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 64'(o_valid), 64'd0);
        check("abort_ready", 64'(o_ready), 64'd1);
        check("abort_result", 64'(result), 64'd0);
        sb.delete();
        repeat (N + 5) @(negedge clk);
        check("abort_no_output", 64'(o_valid), 64'd0);
        issue(MDU_MUL, 32'h0001_0003, 32'h0000_0101); complete(0);

        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 25; k++) begin
                x   = $urandom;
                y   = $urandom;
                sel = $urandom_range(0, 9);
                if (sel == 0) y = '0;
                else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                else if (sel == 2) y = 32'($urandom_range(1, 15));
                issue(mdu_control_t'(op), x, y);
                complete($urandom_range(0, 2));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
